// File: rtl/srv1_bus_pkg.sv
// Shared types and constants for the core-to-system-bus data bridge.
package srv1_bus_pkg;

    localparam int MASK_W          = 4;
    localparam int DEFAULT_TIMEOUT = 255;
    localparam int BUS_ADDR_W      = 30;
    localparam int BUS_DATA_W      = 32;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RESP,
        DONE
    } bus_state_e;

    typedef struct packed {
        logic                  we;
        logic [BUS_ADDR_W-1:0] addr;
        logic [MASK_W-1:0]     mask;
        logic [BUS_DATA_W-1:0] wdata;
        logic                  lock;
    } bus_req_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Response-wait counter: cleared at grant, counts waiting cycles and flags the
// last permitted cycle so the bridge can abort a silent bus.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic async_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // Saturates on the last cycle so an unconsumed expiry never wraps.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == LAST_COUNT);

endmodule

// File: rtl/data_bus_bridge.sv
// Turns the core's single-cycle data request into a granted, acknowledged
// system-bus transaction, stalling the core until the bus answers.
module data_bus_bridge
    import srv1_bus_pkg::*;
#(
    parameter int ADDR_W         = BUS_ADDR_W,
    parameter int DATA_W         = BUS_DATA_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              async_rst_n,
    input  logic              clk_en,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [MASK_W-1:0] core_mask,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic              core_lock,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    output logic              core_err,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [MASK_W-1:0] bus_mask,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_lock,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    bus_state_e state_q;
    bus_state_e state_d;
    bus_req_t   req_q;
    logic       timeout_expired;
    logic       cnt_clear;
    logic       cnt_enable;

    assign cnt_clear  = clk_en && (state_q == ADDR) && bus_gnt;
    assign cnt_enable = clk_en && (state_q == RESP);

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .async_rst_n(async_rst_n),
        .clear      (cnt_clear),
        .enable     (cnt_enable),
        .expired    (timeout_expired)
    );

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    // An empty byte mask completes without touching the bus.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (core_req) begin
                    state_d = (core_mask != '0) ? ADDR : DONE;
                end
            end
            ADDR: begin
                if (bus_gnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus_rvalid || timeout_expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus_req    = 1'b0;
        core_stall = 1'b0;
        case (state_q)
            IDLE: core_stall = core_req;
            ADDR: begin
                bus_req    = 1'b1;
                core_stall = 1'b1;
            end
            RESP: core_stall = 1'b1;
            default: begin
                bus_req    = 1'b0;
                core_stall = 1'b0;
            end
        endcase
    end

    // The lock survives idle gaps only while the core keeps asserting it;
    // an acknowledge that arrives on the timeout cycle still counts as success.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            req_q      <= '0;
            core_rdata <= '0;
            core_err   <= 1'b0;
        end else if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (core_req) begin
                        req_q    <= '{we: core_we, addr: core_addr, mask: core_mask,
                                      wdata: core_wdata, lock: core_lock};
                        core_err <= 1'b0;
                    end else begin
                        req_q.lock <= req_q.lock & core_lock;
                    end
                end
                RESP: begin
                    if (bus_rvalid) begin
                        if (!req_q.we) begin
                            core_rdata <= bus_rdata;
                        end
                    end else if (timeout_expired) begin
                        core_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus_we    = req_q.we;
    assign bus_addr  = req_q.addr;
    assign bus_mask  = req_q.mask;
    assign bus_wdata = req_q.wdata;
    assign bus_lock  = req_q.lock;

endmodule
